// File: rtl/regfile_arbiter_if.sv
// Requester and regfile-side signal bundle for regfile_arbiter.
// slave:   the arbiter's view.
// master:  the requesters' view.
// regfile: the register file's view (write port plus combinational read port).
interface regfile_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] num0;
    logic [AW-1:0] num1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          rf_write;
    logic [AW-1:0] rf_writenum;
    logic [AW-1:0] rf_readnum;
    logic [DW-1:0] rf_data_in;
    logic [DW-1:0] rf_data_out;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, num0, num1, wdata0, wdata1, rf_data_out,
        output ack0, ack1, rdata0, rdata1, rf_write, rf_writenum, rf_readnum,
               rf_data_in, busy
    );

    modport master (
        output req0, req1, we0, we1, num0, num1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1, busy
    );

    modport regfile (
        input  rf_write, rf_writenum, rf_readnum, rf_data_in,
        output rf_data_out
    );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one 8x16 register file between two requesters.
// Each transaction walks IDLE -> XFER -> ACK (3 cycles); the regfile is driven
// only during XFER and the winner gets a one-cycle ack in ACK.
// Optional macro RF_ARB_FIXED_PRIO_EN: port 0 always wins a tie (default is
// round-robin on the last grant).
module regfile_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic                clk,
    input  logic                reset,
    regfile_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] num_q, num_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          rf_write_q, rf_write_d;
    logic          winner;

    // Pick the port that wins this IDLE cycle (only meaningful when a req is high).
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant_q;
`endif
        end else if (bus.req1) begin
            winner = 1'b1;
        end
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        num_d        = num_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rf_write_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d      = XFER;
                    last_grant_d = winner;
                    owner_d      = winner;
                    we_d         = winner ? bus.we1    : bus.we0;
                    num_d        = winner ? bus.num1   : bus.num0;
                    wdata_d      = winner ? bus.wdata1 : bus.wdata0;
                    rf_write_d   = winner ? bus.we1    : bus.we0;
                end
            end
            XFER: begin
                state_d = ACK;
                if (!we_q) begin
                    if (owner_q) rdata1_d = bus.rf_data_out;
                    else         rdata0_d = bus.rf_data_out;
                end
                if (owner_q) ack1_d = 1'b1;
                else         ack0_d = 1'b1;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset does not gate rf_write already
    // presented in XFER, so a write in flight still commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            num_q        <= '0;
            wdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rf_write_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            num_q        <= num_d;
            wdata_q      <= wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            rf_write_q   <= rf_write_d;
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.rf_write    = rf_write_q;
    assign bus.rf_writenum = num_q;
    assign bus.rf_readnum  = num_q;
    assign bus.rf_data_in  = wdata_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
